// File: rtl/set_region_counter.sv
// -----------------------------------------------------------------------------
// set_region_counter
//
// Serially scans the integer grid x,y = 1..GRID_N (one point per clock) and
// counts the points that satisfy a set expression over three circles A, B, C.
// A job is started by a one-cycle en while idle; busy covers the scan and
// valid strobes once when candidate is updated with the final count.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   en         start pulse, sampled only while busy=0
//   central    {xA,yA,xB,yB,xC,yC}, COORD_W bits each, A in the MSBs
//   radius     {rA,rB,rC}, COORD_W bits each, A in the MSBs
//   mode       set expression select, latched with en
//   busy       high from the accepting edge until the result cycle
//   valid      one-cycle result strobe
//   candidate  point count, held until the next result
//
// Optional feature macro: SET_PIPE_COMPARE_EN
//   When defined, the per-circle inclusion bits are registered before the
//   mode/accumulate stage and a one-cycle drain state follows the scan, so
//   the result appears one clock later. Counts are identical.
// -----------------------------------------------------------------------------
module set_region_counter #(
   parameter int GRID_N  = 8,
   parameter int COORD_W = 4,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [6*COORD_W-1:0]   central,
   input  logic [3*COORD_W-1:0]   radius,
   input  logic [2:0]             mode,
   output logic                   busy,
   output logic                   valid,
   output logic [CNT_W-1:0]       candidate
);

   localparam int               IDX_W   = $clog2(GRID_N + 1);
   localparam logic [IDX_W-1:0] LP_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(GRID_N);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

`ifdef SET_PIPE_COMPARE_EN
   localparam state_t LP_AFTER_SCAN = S_DRAIN;
`else
   localparam state_t LP_AFTER_SCAN = S_DONE;
`endif

   // (px-cx)^2 + (py-cy)^2 <= r^2 with signed differences and a sum wide
   // enough that it can never overflow.
   function automatic logic f_in_circle(
      input logic [COORD_W-1:0] px,
      input logic [COORD_W-1:0] py,
      input logic [COORD_W-1:0] cx,
      input logic [COORD_W-1:0] cy,
      input logic [COORD_W-1:0] rr
   );
      logic signed [COORD_W:0]     dx;
      logic signed [COORD_W:0]     dy;
      logic signed [2*COORD_W+1:0] dxe;
      logic signed [2*COORD_W+1:0] dye;
      logic signed [2*COORD_W+1:0] sqx;
      logic signed [2*COORD_W+1:0] sqy;
      logic        [2*COORD_W+2:0] d2;
      logic        [2*COORD_W-1:0] r2;
      dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
      dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
      dxe = {{(COORD_W+1){dx[COORD_W]}}, dx};
      dye = {{(COORD_W+1){dy[COORD_W]}}, dy};
      sqx = dxe * dxe;
      sqy = dye * dye;
      d2  = {1'b0, sqx} + {1'b0, sqy};
      r2  = {{COORD_W{1'b0}}, rr} * {{COORD_W{1'b0}}, rr};
      return (d2 <= {3'b000, r2});
   endfunction

   state_t                 r_state;
   logic [6*COORD_W-1:0]   r_central;
   logic [3*COORD_W-1:0]   r_radius;
   logic [2:0]             r_mode;
   logic [IDX_W-1:0]       r_x;
   logic [IDX_W-1:0]       r_y;
   logic [CNT_W-1:0]       r_acc;
   logic                   r_busy;
   logic                   r_valid;
   logic [CNT_W-1:0]       r_candidate;

   logic [COORD_W-1:0]     w_px;
   logic [COORD_W-1:0]     w_py;
   logic [2:0]             w_inc;       // {a,b,c} for the current point
   logic [2:0]             w_acc_bits;  // {a,b,c} seen by the accumulate stage
   logic                   w_acc_en;
   logic                   w_sel;

   assign w_px = COORD_W'(r_x);
   assign w_py = COORD_W'(r_y);

   assign w_inc[2] = f_in_circle(w_px, w_py, r_central[6*COORD_W-1 -: COORD_W],
                                 r_central[5*COORD_W-1 -: COORD_W], r_radius[3*COORD_W-1 -: COORD_W]);
   assign w_inc[1] = f_in_circle(w_px, w_py, r_central[4*COORD_W-1 -: COORD_W],
                                 r_central[3*COORD_W-1 -: COORD_W], r_radius[2*COORD_W-1 -: COORD_W]);
   assign w_inc[0] = f_in_circle(w_px, w_py, r_central[2*COORD_W-1 -: COORD_W],
                                 r_central[COORD_W-1 -: COORD_W], r_radius[COORD_W-1 -: COORD_W]);

`ifdef SET_PIPE_COMPARE_EN
   logic [2:0] r_inc;
   logic       r_inc_vld;

   // Compare stage: hold the inclusion bits of the point scanned last cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inc     <= 3'b000;
         r_inc_vld <= 1'b0;
      end else begin
         r_inc     <= w_inc;
         r_inc_vld <= (r_state == S_SCAN);
      end
   end

   assign w_acc_bits = r_inc;
   assign w_acc_en   = r_inc_vld;
`else
   assign w_acc_bits = w_inc;
   assign w_acc_en   = (r_state == S_SCAN);
`endif

   // Set expression over the inclusion bits.
   always_comb begin
      w_sel = 1'b0;
      case (r_mode)
         3'b000:  w_sel = w_acc_bits[2];
         3'b001:  w_sel = w_acc_bits[2] & w_acc_bits[1];
         3'b010:  w_sel = w_acc_bits[2] ^ w_acc_bits[1];
         3'b011:  w_sel = (w_acc_bits[2] & w_acc_bits[1] & ~w_acc_bits[0]) |
                          (w_acc_bits[2] & ~w_acc_bits[1] & w_acc_bits[0]) |
                          (~w_acc_bits[2] & w_acc_bits[1] & w_acc_bits[0]);
         3'b100:  w_sel = w_acc_bits[2] | w_acc_bits[1];
         3'b101:  w_sel = |w_acc_bits;
         3'b110:  w_sel = &w_acc_bits;
         3'b111:  w_sel = ^w_acc_bits;
         default: w_sel = 1'b0;
      endcase
   end

   // Control FSM: job acceptance, scan indices, accumulator and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_central   <= {(6*COORD_W){1'b0}};
         r_radius    <= {(3*COORD_W){1'b0}};
         r_mode      <= 3'b000;
         r_x         <= {IDX_W{1'b0}};
         r_y         <= {IDX_W{1'b0}};
         r_acc       <= {CNT_W{1'b0}};
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
         r_candidate <= {CNT_W{1'b0}};
      end else begin
         r_valid <= 1'b0;
         if (w_acc_en) begin
            r_acc <= r_acc + CNT_W'(w_sel);
         end
         case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_central <= central;
                  r_radius  <= radius;
                  r_mode    <= mode;
                  r_acc     <= {CNT_W{1'b0}};
                  r_x       <= LP_ONE;
                  r_y       <= LP_ONE;
                  r_busy    <= 1'b1;
                  r_state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (r_y == LP_LAST) begin
                  r_y <= LP_ONE;
                  if (r_x == LP_LAST) begin
                     r_state <= LP_AFTER_SCAN;
                  end else begin
                     r_x <= r_x + LP_ONE;
                  end
               end else begin
                  r_y <= r_y + LP_ONE;
               end
            end
            // Lets the last registered compare result reach the accumulator.
            S_DRAIN: r_state <= S_DONE;
            S_DONE: begin
               r_candidate <= r_acc;
               r_valid     <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign valid     = r_valid;
   assign candidate = r_candidate;

endmodule

// File: tb/tb_set_region_counter.sv
// -----------------------------------------------------------------------------
// tb_set_region_counter
//
// Scoreboard bench: the driver pushes the expected count and accept cycle of
// each job; an independent monitor pops and checks count, latency and strobe
// shape whenever valid is seen. Random jobs are checked against a reference
// that counts grid points directly from the circle and set definitions.
// -----------------------------------------------------------------------------
module tb_set_region_counter;

   localparam int GN = 8;
   localparam int CW = 4;
   localparam int NW = 8;
`ifdef SET_PIPE_COMPARE_EN
   localparam int LAT = GN*GN + 2;
`else
   localparam int LAT = GN*GN + 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic [23:0]   central = 24'h000000;
   logic [11:0]   radius  = 12'h000;
   logic [2:0]    mode    = 3'b000;
   logic          busy;
   logic          valid;
   logic [NW-1:0] candidate;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int cnt;
      int acc_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic prev_valid = 1'b0;

   set_region_counter #(.GRID_N(GN), .COORD_W(CW), .CNT_W(NW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .central   (central),
      .radius    (radius),
      .mode      (mode),
      .busy      (busy),
      .valid     (valid),
      .candidate (candidate)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Count grid points straight from the definition of each set expression.
   function automatic int ref_count(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m);
      int   cnt;
      int   n;
      int   cx;
      int   cy;
      int   rk;
      logic [2:0] inb;
      logic hit;
      cnt = 0;
      for (int x = 1; x <= GN; x++) begin
         for (int y = 1; y <= GN; y++) begin
            for (int k = 0; k < 3; k++) begin
               cx = int'(c[(5-2*k)*4 +: 4]);
               cy = int'(c[(4-2*k)*4 +: 4]);
               rk = int'(r[(2-k)*4 +: 4]);
               inb[2-k] = ((x-cx)*(x-cx) + (y-cy)*(y-cy) <= rk*rk);
            end
            n = int'(inb[2]) + int'(inb[1]) + int'(inb[0]);
            case (m)
               3'd0:    hit = inb[2];
               3'd1:    hit = inb[2] && inb[1];
               3'd2:    hit = (inb[2] != inb[1]);
               3'd3:    hit = (n == 2);
               3'd4:    hit = inb[2] || inb[1];
               3'd5:    hit = (n >= 1);
               3'd6:    hit = (n == 3);
               3'd7:    hit = (n % 2 == 1);
               default: hit = 1'b0;
            endcase
            cnt += int'(hit);
         end
      end
      return cnt;
   endfunction

   // Monitor: every valid strobe must match the oldest outstanding job.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", int'(valid), 0);
            end else begin
               mon_e = sb.pop_front();
               chk("candidate", int'(candidate), mon_e.cnt);
               chk("latency", cyc - mon_e.acc_cyc, LAT);
               chk("busy_at_valid", int'(busy), 0);
            end
            chk("valid_one_cycle", int'(prev_valid), 0);
         end
         prev_valid = valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   // Called at a negedge with busy low; the job is accepted on the next edge.
   task automatic start_job(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m, input int expc);
      exp_t e;
      central = c;
      radius  = r;
      mode    = m;
      en      = 1'b1;
      e.cnt     = expc;
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      en      = 1'b0;
      central = 24'($urandom);
      radius  = 12'($urandom);
      mode    = 3'($urandom);
      chk("busy_after_accept", int'(busy), 1);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (sb.size() != 0 && k < LAT + 20) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         chk("result_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   localparam int NDIR = 11;
   logic [23:0] d_c [NDIR] = '{24'h440000, 24'h445400, 24'h445400, 24'h445400, 24'h110000,
                               24'h000000, 24'h440000, 24'h444444, 24'h444444, 24'h444444, 24'h444444};
   logic [11:0] d_r [NDIR] = '{12'h200, 12'h220, 12'h220, 12'h220, 12'h300,
                               12'h000, 12'hF00, 12'h222, 12'h222, 12'h222, 12'h222};
   logic [2:0]  d_m [NDIR] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000,
                               3'b000, 3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
   int          d_e [NDIR] = '{13, 8, 10, 18, 11, 0, 64, 0, 13, 13, 13};

   initial begin
      logic [23:0] rc;
      logic [11:0] rr;
      logic [2:0]  rm;
      int          k;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_valid", int'(valid), 0);
      chk("reset_candidate", int'(candidate), 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases with known counts.
      for (int i = 0; i < NDIR; i++) begin
         start_job(d_c[i], d_r[i], d_m[i], d_e[i]);
         wait_done();
      end

      // en during the scan with different inputs must not disturb the job.
      start_job(24'h440000, 12'h200, 3'b000, 13);
      repeat (10) @(negedge clk);
      central = 24'h444444;
      radius  = 12'hFFF;
      mode    = 3'b101;
      en      = 1'b1;
      @(negedge clk);
      en      = 1'b0;
      wait_done();

      // Second job started in the valid cycle of the first.
      start_job(24'h445400, 12'h220, 3'b100, 18);
      k = 0;
      while (!valid && k < LAT + 20) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_valid_seen", int'(valid), 1);
      start_job(24'h445400, 12'h220, 3'b001, 8);
      wait_done();

      // Reset in the middle of a scan aborts it silently.
      start_job(24'h440000, 12'hF00, 3'b000, 64);
      repeat (29) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_candidate", int'(candidate), 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 10) @(negedge clk);
      chk("midrst_stays_idle", int'(busy), 0);
      start_job(24'h110000, 12'h300, 3'b000, 11);
      wait_done();

      // Randomised jobs against the reference count.
      for (int i = 0; i < 25; i++) begin
         rc = 24'($urandom);
         rr = 12'($urandom);
         rm = 3'($urandom_range(0, 7));
         start_job(rc, rr, rm, ref_count(rc, rr, rm));
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/set_region_counter.md
Name: set_region_counter

Overview:
- Parametrised successor to the 2015 two-circle set counter.
- Counts integer grid points (x,y), x,y in 1..GRID_N, that satisfy a set expression over up to three circles A, B and C.
- Serial scan, one grid point per clock; busy/valid handshake with the existing testfixture style.
- Adds three-circle modes, a configurable grid size and coordinate width, and an optional compare pipeline stage.

Parameters:
- GRID_N, 8: grid side; points scanned x,y = 1..GRID_N.
- COORD_W, 4: width of each centre coordinate and each radius.
- CNT_W, 8: candidate width; must satisfy 2^CNT_W > GRID_N*GRID_N.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start pulse; sampled only when busy=0.
- central  in  6*COORD_W  {xA,yA,xB,yB,xC,yC}, A in MSBs, unsigned.
- radius  in  3*COORD_W  {rA,rB,rC}, A in MSBs, unsigned.
- mode  in  3  set expression select; sampled with en.
- busy  out  1  high while a job is accepted/scanning.
- valid  out  1  one-cycle result strobe.
- candidate  out  CNT_W  point count; held until next accepted en.

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, valid=0, candidate=0, scan indices and accumulator cleared. Reset asserted mid-scan aborts the job with no valid pulse.
- States:
  - IDLE: en=1 at a clock edge → latch central/radius/mode, clear accumulator, x=y=1, busy=1 → SCAN.
  - SCAN: each cycle evaluates point (x,y). y increments 1..GRID_N; on wrap to 1, x increments. After point (GRID_N,GRID_N) → DONE.
  - DONE: candidate←accumulator, valid=1 for exactly one cycle, busy=0 in the same cycle → IDLE.
- Latency: valid rises GRID_N*GRID_N+1 clocks after the accepting edge (65 for defaults). Next en is accepted in the valid cycle or later.
- en while busy=1 is ignored. Input changes after acceptance have no effect.
- Inclusion per circle k: (x-cxk)^2+(y-cyk)^2 <= rk^2.
  - Signed differences of width COORD_W+1; sums of width 2*COORD_W+3, no overflow.
  - rk=0 includes only the centre, if it is on the grid.
  - Centres outside 1..GRID_N (including 0) are legal: the region is clipped naturally.
- Mode (a,b,c = inclusion bits):
  - 000 a
  - 001 a&b
  - 010 a^b
  - 011 exactly two of a,b,c
  - 100 a|b
  - 101 a|b|c
  - 110 a&b&c
  - 111 a^b^c
- Accumulator adds the selected bit each SCAN cycle. Maximum value GRID_N^2; no saturation needed.

Optional Feature:
- Macro SET_PIPE_COMPARE_EN.
- Defined: squared-distance comparison results are registered before the mode/accumulate stage. A one-cycle drain state follows SCAN, so valid latency becomes GRID_N*GRID_N+2. Counts are unchanged.
- Undefined: single-stage, combinational compare-accumulate; latency GRID_N*GRID_N+1.

Test Plan:
- A=(4,4) r=2, mode 000 → candidate=13; valid exactly 65 cycles after en edge (66 with SET_PIPE_COMPARE_EN).
- A=(4,4) r=2, B=(5,4) r=2: mode 001 → 8; 010 → 10; 100 → 18.
- Clipping: A=(1,1) r=3, mode 000 → 11. A=(0,0) r=0 → 0. A=(4,4) r=15 → 64.
- Three circles, A=B=C=(4,4) r=2: mode 011 → 0; 101 → 13; 110 → 13; 111 → 13.
- Second en pulse mid-scan with different inputs → ignored; result equals the first job's count. Back-to-back en accepted on the valid cycle → correct second result.
- rst pulsed at scan cycle 30 → busy, valid and candidate go 0 immediately with no valid pulse. A fresh job afterwards returns the correct count.
